// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, RV32I opcodes, immediate formats and the decoded bundle shared by the decode stage.
package alu_pkg;
  localparam int XLEN = 32;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  typedef enum logic {IMM_I, IMM_S} imm_fmt_t;
  typedef struct packed {
    logic [XLEN-1:0] rd_data1;
    logic [XLEN-1:0] rd_final2;
    logic [3:0]      alu_main;
    logic [4:0]      rd_addr;
    logic            is_branch;
    logic            illegal;
  } bundle_t;
  // alt selects SUB/SRA over ADD/SRL; the caller decides when funct7 may do that
  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended I/S immediate; both formats share instr[31:25] and differ only in the low five bits.
module imm_gen import alu_pkg::*; (
  input  logic [31:0]     instr,
  input  imm_fmt_t        fmt,
  output logic [XLEN-1:0] imm
);
  logic unused_bits;
  assign unused_bits = ^{instr[19:12], instr[6:0]};
  assign imm = {{(XLEN-11){instr[31]}}, instr[30:25], fmt == IMM_S ? instr[11:7] : instr[24:20]};
endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: RV32I decode into ALU op/operands, registered behind valid/ready; ALU_DEC_SKID_EN adds a skid entry.
module alu_decode_stage import alu_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_final2,
  output logic [3:0]      alu_main,
  output logic [4:0]      rd_addr,
  output logic            is_branch,
  output logic            illegal
);
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [XLEN-1:0] imm;
  imm_fmt_t fmt;
  bundle_t dec, main_q;
  assign opcode = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign fmt = opcode == STORE ? IMM_S : IMM_I;
  imm_gen u_imm (.instr(instr), .fmt(fmt), .imm(imm));
  always_comb begin
    dec.rd_data1 = rs1_val;
    dec.rd_addr = instr[11:7];
    dec.is_branch = opcode == BRANCH;
    dec.rd_final2 = (opcode == OP || opcode == BRANCH) ? rs2_val : imm;
    dec.alu_main = ALU_ADD;
    dec.illegal = 1'b0;
    case (opcode)
      OP: begin
        dec.alu_main = f3_op(f3, f7[5]);
        dec.illegal = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OP_IMM: begin
        dec.alu_main = f3_op(f3, f3 == 3'b101 && f7[5]);
        dec.illegal = (f3 == 3'b001 && f7 != F7_BASE) || (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT);
      end
      LOAD, STORE: begin
      end
      BRANCH: begin
        dec.alu_main = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        dec.illegal = f3[2:1] == 2'b01;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.alu_main = ALU_ADD;
      dec.rd_final2 = '0;
      dec.is_branch = 1'b0;
    end
  end
`ifdef ALU_DEC_SKID_EN
  bundle_t skid_q;
  // in_ready doubles as "skid empty"; a full skid implies the main entry is valid and stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
      out_valid <= 1'b0;
      in_ready <= 1'b1;
    end else if (!in_ready) begin
      if (out_ready) begin
        main_q <= skid_q;
        in_ready <= 1'b1;
      end
    end else if (in_valid) begin
      if (out_valid && !out_ready) begin
        skid_q <= dec;
        in_ready <= 1'b0;
      end else begin
        main_q <= dec;
        out_valid <= 1'b1;
      end
    end else if (out_ready) out_valid <= 1'b0;
  end
`else
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) main_q <= dec;
    end
  end
`endif
  assign {rd_data1, rd_final2, alu_main, rd_addr, is_branch, illegal} = main_q;
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: randomized scoreboard bench with a mnemonic-level reference decoder.
module tb_alu_decode_stage;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        br;
    logic        ill;
  } exp_t;

  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, is_branch, illegal;
  logic [31:0] instr = 0, rs1_val = 0, rs2_val = 0, rd_data1, rd_final2;
  logic [3:0] alu_main;
  logic [4:0] rd_addr;
  exp_t bundle, held, want;
  exp_t q[$];
  int n_cmp = 0, n_fail = 0, mode = 0, cyc = 0, base = 0;
  logic stalled = 0;
  int unsigned code[string];

  alu_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .out_valid(out_valid), .out_ready(out_ready),
    .rd_data1(rd_data1), .rd_final2(rd_final2), .alu_main(alu_main), .rd_addr(rd_addr),
    .is_branch(is_branch), .illegal(illegal)
  );

  always #5 clk = ~clk;
  assign bundle = {rd_data1, rd_final2, alu_main, rd_addr, is_branch, illegal};

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    string names[8] = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};
    string brs[8] = '{"sub", "sub", "", "", "slt", "slt", "sltu", "sltu"};
    logic [6:0] opc = ins[6:0];
    logic [6:0] f7 = ins[31:25];
    int f3 = int'(ins[14:12]);
    logic signed [11:0] i12 = ins[31:20];
    logic signed [11:0] s12 = {ins[31:25], ins[11:7]};
    string m = "";
    logic [31:0] opb = b;
    logic br = 1'b0;
    case (opc)
      7'h33: m = f7 == 0 ? names[f3] : (f7 == 7'h20 && f3 == 0) ? "sub" : (f7 == 7'h20 && f3 == 5) ? "sra" : "";
      7'h13: begin
        m = (f3 == 1 && f7 != 0) ? "" : (f3 == 5 && f7 == 7'h20) ? "sra" : (f3 == 5 && f7 != 0) ? "" : names[f3];
        opb = 32'(i12);
      end
      7'h03: begin m = "add"; opb = 32'(i12); end
      7'h23: begin m = "add"; opb = 32'(s12); end
      7'h63: begin m = brs[f3]; br = 1'b1; end
      default: m = "";
    endcase
    if (m == "") return '{a, 32'h0, 4'h0, ins[11:7], 1'b0, 1'b1};
    return '{a, opb, 4'(code[m]), ins[11:7], br, 1'b0};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    int k = $urandom_range(6);
    int c = $urandom_range(2);
    if (c == 0) r[31:25] = 7'h00;
    else if (c == 1) r[31:25] = 7'h20;
    case (k)
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h03;
      3: r[6:0] = 7'h23;
      4: r[6:0] = 7'h63;
      5: r[6:0] = 7'h7F;
      default: ;
    endcase
    return r;
  endfunction

  task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    int waited = 0;
    in_valid = 1; instr = ins; rs1_val = a; rs2_val = b;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(ins, a, b));
        break;
      end
      if (++waited > 50) begin
        check("send_timeout", waited, 0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    check(name, q.size(), 0);
    @(posedge clk); #1;
  endtask

  // out_ready driver: 0 low, 1 random, 2 scheduled stall, 3 high
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    out_ready = mode == 1 ? ($urandom_range(3) != 0) : mode == 2 ? !((cyc - base) inside {[3:5]}) : mode == 3;
  end

  initial forever begin
    @(negedge clk);
    if (rst) stalled = 0;
    else begin
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_bundle", bundle, held);
      end
`ifndef ALU_DEC_SKID_EN
      check("in_ready_comb", in_ready, !out_valid || out_ready);
`else
      if (mode == 2 && cyc - base == 3) check("in_ready_stall_start", in_ready, 1);
      if (mode == 2 && cyc - base == 4) check("in_ready_drop", in_ready, 0);
`endif
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", out_valid, 0);
        else begin
          want = q.pop_front();
          check("bundle", bundle, want);
        end
      end
      stalled = out_valid && !out_ready;
      held = bundle;
    end
  end

  initial begin
    code["add"] = 0; code["sub"] = 1; code["and"] = 2; code["or"] = 3; code["xor"] = 4;
    code["slt"] = 5; code["sltu"] = 7; code["sll"] = 8; code["sra"] = 9; code["srl"] = 15;
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_bundle", bundle, 0);
    @(negedge clk); rst = 0; mode = 3;
    @(posedge clk); #1;
    send(32'h002081B3, 5, 7);
    send(32'hFFF00093, $urandom, $urandom);
    send(32'h4030D093, $urandom, $urandom);
    send(32'h0020E063, $urandom, $urandom);
    send(32'h0000007F, $urandom, $urandom);
    send(32'hFE20AE23, $urandom, $urandom);
    drain("drain_directed");
    @(negedge clk); base = cyc; mode = 2;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(rand_instr(), 100 + i, $urandom);
    drain("drain_stall");
    mode = 0;
    @(posedge clk); #1;
    in_valid = 1; instr = 32'h002081B3; rs1_val = 32'hDEAD; rs2_val = 32'hBEEF;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 0;
    check("pre_reset_valid", out_valid, 1);
    #2 rst = 1;
    #1;
    check("async_reset_valid", out_valid, 0);
    check("async_reset_bundle", bundle, 0);
    check("async_reset_in_ready", in_ready, 1);
    @(posedge clk); @(negedge clk); rst = 0; mode = 3;
    repeat (4) begin
      @(negedge clk);
      check("post_reset_no_stale", out_valid, 0);
      check("post_reset_in_ready", in_ready, 1);
    end
    @(posedge clk); #1;
    mode = 1;
    repeat (300) begin
      send(rand_instr(), $urandom, $urandom);
      if ($urandom_range(4) == 0) begin @(posedge clk); #1; end
    end
    mode = 3;
    drain("drain_random");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
